ioctl_upload_reader: RTL
========================

Name: ioctl_upload_reader

Overview:
- Reads back a contiguous byte region from SDRAM and presents it to data_io, one byte per host read strobe. Used for hiscore and NVRAM save.
- It is the read-side counterpart of the ioctl download path, which writes bytes into SDRAM through port1 using toggle requests.
- It sits between data_io's upload interface and an sdram port that uses the req/ack toggle protocol, returning 16-bit words.

Parameters:
- BASE, 25'h0, byte base address in SDRAM of the region to upload.
- LENGTH, 25'd256, number of bytes to upload (>=1).

Ports:
- clk_sys  in  1  system clock (40 MHz)
- reset_n  in  1  synchronous, active-low reset
- ioctl_upload  in  1  high while the host upload is active (level)
- ioctl_rd  in  1  one-cycle strobe: host consumes current ioctl_din and wants the next byte
- ioctl_din  out  8  byte presented to data_io
- mem_req  out  1  toggle request to sdram port
- mem_ack  in  1  toggle acknowledge; mem_ack==mem_req means idle or complete
- mem_a  out  23  word address = (BASE+byte_cnt)>>1
- mem_q  in  16  read word; valid in the cycle mem_ack becomes equal to mem_req
- busy  out  1  high from upload start until DONE or IDLE
- done  out  1  high once LENGTH bytes have been consumed; cleared on next upload start
- underrun  out  1  sticky: ioctl_rd arrived while the byte was not ready; cleared on upload start

Behaviour:
- Reset (reset_n=0 at a clk_sys edge):
  - state=IDLE; mem_req<=mem_ack (no outstanding request); mem_a=0; ioctl_din=8'hFF.
  - busy=0, done=0, underrun=0, byte_cnt=0, word_reg=16'hFFFF.
- States: IDLE, FETCH, READY, DONE, DRAIN.
- Upload start:
  - Rising edge of ioctl_upload (registered compare) in IDLE clears done and underrun and sets byte_cnt=0.
  - Then mem_a<=(BASE)>>1, mem_req toggles, busy=1, state=FETCH.
- FETCH:
  - Wait for mem_ack==mem_req.
  - In that cycle latch word_reg<=mem_q and go to READY.
  - From the next cycle, ioctl_din shows word_reg[15:8] if (BASE+byte_cnt)[0] is 1, otherwise word_reg[7:0]. Little-endian, matching the download packing.
- READY, on ioctl_rd:
  - byte_cnt increments.
  - If the new byte_cnt==LENGTH: state=DONE, done=1, busy=0.
  - Otherwise, if the new byte address is even (word boundary crossed): mem_a updates, mem_req toggles, state=FETCH.
  - Otherwise (same word): stay in READY; ioctl_din switches to the high byte next cycle.
- ioctl_rd in FETCH:
  - underrun<=1; the strobe is ignored (byte_cnt does not advance).
  - ioctl_din holds its previous value.
- DONE:
  - ioctl_din=8'hFF; ioctl_rd is ignored.
  - Falling edge of ioctl_upload goes to IDLE with done held.
- Abort (ioctl_upload falls while in FETCH or READY):
  - busy=0, done stays 0.
  - If a request is outstanding (mem_req!=mem_ack), go to DRAIN, wait for ack, discard mem_q, then IDLE. Otherwise go directly to IDLE.
  - A new upload start seen while in DRAIN is deferred until IDLE: the registered edge is kept pending.
- Odd BASE: the first fetch covers the word containing BASE and the high byte is presented first. LENGTH odd/even are both handled by the byte_cnt compare.
- Latency:
  - Byte on a word boundary: ready 1 cycle after mem_ack returns.
  - Intra-word byte: ioctl_din valid the cycle after ioctl_rd.
- Widths:
  - byte_cnt is 25 bits.
  - The address sum BASE+byte_cnt is 25 bits; mem_a takes bits [23:1]. Bit 24 is dropped and must be 0 by construction; an elaboration-time check enforces BASE+LENGTH<=2^24.
- Simultaneous reset and ack: reset wins; mem_req is re-aligned to mem_ack.

Decomposition:
- Shared package upload_pkg:
  - state enum (IDLE, FETCH, READY, DONE, DRAIN)
  - constant FILL_BYTE=8'hFF
  - function byte_sel(word, odd)
- Sub-module toggle_req_if: owns mem_req/mem_ack, the outstanding flag, and the completion pulse. It is reusable by other SDRAM port clients.

Test Plan:
- BASE=0, LENGTH=4, memory words 16'h2211, 16'h4433; upload high, 4 ioctl_rd strobes with ack delay 5 cycles:
  - ioctl_din sequence 11,22,33,44.
  - exactly 2 mem_req toggles with mem_a 0,1.
  - done=1, busy=0.
- BASE=1, LENGTH=3, words at 0: 16'hBBAA, at 1: 16'hDDCC:
  - bytes BB,CC,DD.
  - mem_a sequence 0,1.
- ioctl_rd issued 1 cycle after a word-boundary strobe while ack delayed 20 cycles:
  - underrun=1, byte_cnt unchanged.
  - ioctl_din after ack = correct next byte.
- ioctl_upload dropped 2 cycles after a fetch toggle, ack arrives 10 cycles later:
  - state DRAIN then IDLE; no further toggles; done=0.
  - A restart then begins at byte 0 with underrun cleared.
- reset_n=0 mid-READY with an outstanding request:
  - next cycle all outputs at reset values; mem_req==mem_ack.
  - ioctl_din=FF.
- After done, extra ioctl_rd strobes:
  - ioctl_din stays FF; no mem_req toggle; byte_cnt stays LENGTH.

Source files
------------

// File: rtl/ioctl_upload_reader_pkg.sv
// upload_pkg: shared states, fill byte and byte lane selection for the ioctl upload reader
package upload_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, READY, DONE, DRAIN} state_t;
  localparam logic [7:0] FILL_BYTE = 8'hFF;
  // Little-endian packing, matching how the download path fills SDRAM words
  function automatic logic [7:0] byte_sel(input logic [15:0] word, input logic odd);
    return odd ? word[15:8] : word[7:0];
  endfunction
endpackage

// File: rtl/ioctl_upload_reader_if.sv
// ioctl_upload_reader_if: SDRAM port bus using the req/ack toggle protocol with 16-bit read data
interface ioctl_upload_reader_if;
  logic        mem_req;
  logic        mem_ack;
  logic [22:0] mem_a;
  logic [15:0] mem_q;
  modport master (output mem_req, mem_a, input mem_ack, mem_q);
  modport slave (input mem_req, mem_a, output mem_ack, mem_q);
endinterface

// File: rtl/ioctl_upload_reader_toggle_req.sv
// toggle_req_if: owns a toggle request line, reporting outstanding state and a completion pulse
module toggle_req_if (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic issue,
  input  logic mem_ack,
  output logic mem_req,
  output logic pending,
  output logic complete
);
  logic waiting;
  assign pending = mem_req != mem_ack;
  assign complete = waiting && !pending;
  // Reset re-aligns the request to the ack so an in-flight request is abandoned
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      mem_req <= mem_ack;
      waiting <= 1'b0;
    end else begin
      mem_req <= mem_req ^ issue;
      waiting <= issue | (waiting & pending);
    end
  end
endmodule

// File: rtl/ioctl_upload_reader.sv
// ioctl_upload_reader: streams a contiguous SDRAM byte region to data_io, one byte per host read strobe
module ioctl_upload_reader
  import upload_pkg::*;
#(
  parameter logic [24:0] BASE   = 25'h0,
  parameter logic [24:0] LENGTH = 25'd256
) (
  input  logic                          clk_sys,
  input  logic                          reset_n,
  input  logic                          ioctl_upload,
  input  logic                          ioctl_rd,
  output logic [7:0]                    ioctl_din,
  ioctl_upload_reader_if.master         mem,
  output logic                          busy,
  output logic                          done,
  output logic                          underrun
);
  if (({1'b0, BASE} + {1'b0, LENGTH} > 26'h1000000) || (LENGTH == 25'd0)) begin : g_bad_region
    $error("ioctl_upload_reader: region must be non-empty and lie below 2^24");
  end
  state_t      state, state_n;
  logic [24:0] byte_cnt, cnt_n, cnt_inc;
  logic [15:0] word_reg, word_n;
  logic [22:0] a_n;
  logic [7:0]  din_n;
  logic [23:0] next_addr;
  logic        addr_odd, upl_r, start_pend, pend_n, busy_n, done_n, under_n;
  logic        issue, pending, complete, rise;
  assign cnt_inc   = byte_cnt + 25'd1;
  assign addr_odd  = BASE[0] ^ byte_cnt[0];
  assign next_addr = 24'(BASE + cnt_inc);
  assign rise      = ioctl_upload & ~upl_r;
  toggle_req_if u_req (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .issue   (issue),
    .mem_ack (mem.mem_ack),
    .mem_req (mem.mem_req),
    .pending (pending),
    .complete(complete)
  );
  always_comb begin
    state_n = state;
    cnt_n   = byte_cnt;
    word_n  = word_reg;
    a_n     = mem.mem_a;
    din_n   = ioctl_din;
    busy_n  = busy;
    done_n  = done;
    under_n = underrun;
    pend_n  = start_pend;
    issue   = 1'b0;
    case (state)
      IDLE: begin
        pend_n = 1'b0;
        if ((rise || start_pend) && ioctl_upload) begin
          done_n  = 1'b0;
          under_n = 1'b0;
          cnt_n   = '0;
          a_n     = BASE[23:1];
          issue   = 1'b1;
          busy_n  = 1'b1;
          state_n = FETCH;
        end
      end
      FETCH: begin
        if (!ioctl_upload) begin
          busy_n  = 1'b0;
          state_n = pending ? DRAIN : IDLE;
        end else begin
          under_n = underrun | ioctl_rd;
          if (complete) begin
            word_n  = mem.mem_q;
            din_n   = byte_sel(mem.mem_q, addr_odd);
            state_n = READY;
          end
        end
      end
      READY: begin
        if (!ioctl_upload) begin
          busy_n  = 1'b0;
          state_n = IDLE;
        end else if (ioctl_rd) begin
          cnt_n = cnt_inc;
          if (cnt_inc == LENGTH) begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            din_n   = FILL_BYTE;
            state_n = DONE;
          end else if (!next_addr[0]) begin
            a_n     = next_addr[23:1];
            issue   = 1'b1;
            state_n = FETCH;
          end else begin
            din_n = byte_sel(word_reg, 1'b1);
          end
        end
      end
      DONE: begin
        din_n   = FILL_BYTE;
        state_n = ioctl_upload ? DONE : IDLE;
      end
      DRAIN: begin
        pend_n  = start_pend | rise;
        state_n = pending ? DRAIN : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      word_reg   <= 16'hFFFF;
      mem.mem_a  <= '0;
      ioctl_din  <= FILL_BYTE;
      busy       <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
      upl_r      <= 1'b0;
      start_pend <= 1'b0;
    end else begin
      state      <= state_n;
      byte_cnt   <= cnt_n;
      word_reg   <= word_n;
      mem.mem_a  <= a_n;
      ioctl_din  <= din_n;
      busy       <= busy_n;
      done       <= done_n;
      underrun   <= under_n;
      upl_r      <= ioctl_upload;
      start_pend <= pend_n;
    end
  end
endmodule
